mux_nch_reg: RTL and testbench
==============================

Name: mux_nch_reg

Overview:
- Parametrised N-channel registered data multiplexer for the RISC-SPM datapath, generalising the fixed 5-channel combinational mux.
- Each channel has a valid/ready handshake; the output is a single registered slot with valid/ready backpressure.
- Two selection modes:
  - Mode 0 (directed): the channel is chosen by `sel`.
  - Mode 1 (round-robin): the block arbitrates fairly among all valid channels.
- Sits between register-file/ALU/memory sources and a shared bus consumer.

Parameters:
- WORD_SIZE, 8, data width per channel.
- NUM_CH, 5, number of input channels (legal range 2..16).
- SEL_WIDTH, $clog2(NUM_CH) (derived, localparam), width of `sel` and `out_ch`.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- data_in  input  NUM_CH*WORD_SIZE  packed channel data; channel i occupies bits [i*WORD_SIZE +: WORD_SIZE].
- in_valid  input  NUM_CH  per-channel data valid.
- in_ready  output  NUM_CH  per-channel accept; at most one bit is set at any time.
- mode  input  1  0 = directed by `sel`, 1 = round-robin.
- sel  input  SEL_WIDTH  channel select in mode 0; ignored in mode 1.
- out_data  output  WORD_SIZE  registered selected word.
- out_ch  output  SEL_WIDTH  index of the channel that supplied `out_data`.
- out_valid  output  1  output slot full.
- out_ready  input  1  consumer accept.
- sel_err  output  1  registered flag; 1 when mode 0 and `sel` >= NUM_CH during the previous cycle.

Behaviour:
- Reset values (synchronous, wins over all other activity, including a transfer in the same cycle):
  - out_valid=0, out_data=0, out_ch=0, sel_err=0.
  - Round-robin pointer rr_last=NUM_CH-1.
- Slot free condition: `free = !out_valid || out_ready`.
  - Back-to-back transfers every cycle are allowed while out_ready=1.
- Grant is combinational:
  - Mode 0: `g = sel` if sel < NUM_CH, else no grant.
  - Mode 1: `g` is the first i with in_valid[i]=1, scanning rr_last+1, rr_last+2, … NUM_CH-1, 0, … rr_last (wrap-around). No grant if all in_valid are 0.
- Ready: `in_ready[g] = free`; all other in_ready bits are 0.
  - Mode 0 asserts in_ready[sel] even when in_valid[sel]=0.
  - in_ready never depends combinationally on in_valid of the same channel in mode 0.
- Transfer: occurs when `in_valid[g] && in_ready[g]`. On the next edge:
  - out_data <= channel g word, out_ch <= g, out_valid <= 1.
  - In mode 1 only, rr_last <= g.
- Latency: 1 clock from accepted input to out_valid.
- Drain: if out_valid && out_ready and there is no transfer, out_valid <= 0. out_data and out_ch hold their last values.
- Stall: while out_valid && !out_ready, out_data, out_ch and out_valid are held stable and all in_ready bits are 0.
- Out-of-range select (mode 0, sel >= NUM_CH): no grant and all in_ready=0; sel_err <= 1 on the next edge. sel_err <= 0 in every other case.
  - This replaces the legacy default-output behaviour for undefined selects.
- Mode switch: takes effect in the same cycle, since grant is combinational.
  - A word already in the output slot is unaffected.
  - rr_last is retained across mode 0 periods; mode 0 transfers do not update it.
- Fairness (mode 1): with all channels continuously valid and out_ready=1, grants cycle 0,1,…,NUM_CH-1,0…, starting from channel 0 after reset.

Decomposition:
- Shared package `risc_spm_pkg`:
  - Mode encodings as localparams MODE_DIRECTED=1'b0 and MODE_RR=1'b1.
  - The reset value for data words (WORD_ZERO).
- One natural sub-module, `rr_arbiter`:
  - Parametrised by NUM_CH.
  - Inputs: request vector, last-grant index.
  - Outputs: grant index and grant-valid.
  - Purely combinational; rr_last stays in the parent.
- Parent holds the output register, handshake logic and sel_err.

Test Plan:
- Reset: assert rst for 2 cycles while in_valid=5'b11111 and out_ready=1.
  - During reset: out_valid=0 and out_data=8'h00.
  - After release: out_valid=0 and sel_err=0 until the first edge with a grant.
- Directed sweep (mode 0): data AA, BB, CC, DD, EE on channels 0..4, all valid, out_ready=1, sel stepped 0..7, one value per cycle.
  - For sel 0..4: out_data is AA..EE and out_ch is 0..4, each one cycle later.
  - For sel 5..7: no transfer and sel_err=1 on the following cycle.
- Backpressure (mode 0): sel=2, out_ready=0 for 3 cycles.
  - out_valid=1 with out_data=CC held.
  - in_ready=5'b00000 throughout.
  - Raising out_ready gives one drain cycle then a new CC transfer in the same edge; out_valid stays 1.
- Round-robin fairness (mode 1): all channels valid, out_ready=1, 10 cycles.
  - out_ch sequence 0,1,2,3,4,0,1,2,3,4.
- Round-robin with gaps: in_valid=5'b10010, rr_last=1.
  - Grant 4, then 1, then 4.
  - Drop in_valid[4] mid-sequence: only channel 1 is granted on consecutive transfers.
- Width/depth generality: re-run the directed and round-robin scenarios with WORD_SIZE=16 and NUM_CH=3.
  - sel=3 sets sel_err.
  - out_data carries 16'hA5A5 / 16'h5A5A toggles on all bits in both directions.

Source files
------------

// File: rtl/risc_spm_pkg.sv
// Shared definitions for the RISC-SPM datapath multiplexer: mode encodings
// and the reset value used for data words.
package risc_spm_pkg;

  // Selection mode encodings carried on the mode input.
  localparam logic MODE_DIRECTED = 1'b0;
  localparam logic MODE_RR       = 1'b1;

  // Widest data word any instance is expected to carry; WORD_ZERO is sliced
  // down to the instance width where it is used.
  localparam int MAX_WORD_SIZE = 64;

  // Reset value for registered data words.
  localparam logic [MAX_WORD_SIZE-1:0] WORD_ZERO = '0;

  // Channel count limits for which the grant logic is sized.
  localparam int MIN_NUM_CH = 2;
  localparam int MAX_NUM_CH = 16;

endpackage

// File: rtl/mux_nch_reg_if.sv
// Bundle of the per-channel input handshakes and the registered output slot.
// The slave modport is the multiplexer; the master modport is whatever drives
// the sources and consumes the output.
interface mux_nch_reg_if #(
  parameter int WORD_SIZE = 8,
  parameter int NUM_CH    = 5
);
  localparam int SEL_WIDTH = $clog2(NUM_CH);

  logic [NUM_CH*WORD_SIZE-1:0] data_in;
  logic [NUM_CH-1:0]           in_valid;
  logic [NUM_CH-1:0]           in_ready;
  logic                        mode;
  logic [SEL_WIDTH-1:0]        sel;
  logic [WORD_SIZE-1:0]        out_data;
  logic [SEL_WIDTH-1:0]        out_ch;
  logic                        out_valid;
  logic                        out_ready;
  logic                        sel_err;

  modport slave (
    input  data_in, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid, sel_err
  );

  modport master (
    output data_in, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid, sel_err
  );

endinterface

// File: rtl/mux_nch_reg_rr_arbiter.sv
// Combinational round-robin picker: returns the first requesting channel
// found when scanning upward from the channel after last_i, wrapping at
// NUM_CH. The last-grant pointer itself lives in the parent.
module rr_arbiter #(
  parameter  int NUM_CH    = 5,
  localparam int SEL_WIDTH = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0]    req_i,
  input  logic [SEL_WIDTH-1:0] last_i,
  output logic [SEL_WIDTH-1:0] gnt_o,
  output logic                 gnt_valid_o
);

  // One extra bit so last_i + 1 + offset (at most 2*NUM_CH-1) never overflows.
  localparam int EXT_WIDTH = SEL_WIDTH + 1;
  localparam logic [EXT_WIDTH-1:0] NUM_CH_X = EXT_WIDTH'(NUM_CH);

  logic [EXT_WIDTH-1:0] cand_sum [NUM_CH];
  logic [SEL_WIDTH-1:0] cand_idx [NUM_CH];
  logic [NUM_CH-1:0]    cand_req;

  // Candidate gi is the channel visited gi+1 steps after last_i; a single
  // conditional subtract replaces a modulo because the sum is below 2*NUM_CH.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
    assign cand_sum[gi] = EXT_WIDTH'(last_i) + EXT_WIDTH'(gi + 1);
    assign cand_idx[gi] = (cand_sum[gi] >= NUM_CH_X) ?
                          SEL_WIDTH'(cand_sum[gi] - NUM_CH_X) :
                          SEL_WIDTH'(cand_sum[gi]);
    assign cand_req[gi] = req_i[cand_idx[gi]];
  end

  // Priority pick: the lowest scan offset with a request wins, so iterate
  // from the far end and let nearer candidates overwrite.
  always_comb begin
    gnt_o       = '0;
    gnt_valid_o = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        gnt_o       = cand_idx[k];
        gnt_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nch_reg.sv
// N-channel registered data multiplexer. Each channel offers a word with a
// valid/ready handshake; one channel is granted per cycle (directed by sel or
// round-robin) and its word lands in a single registered output slot that
// drains under out_ready backpressure.
module mux_nch_reg
  import risc_spm_pkg::*;
#(
  parameter  int WORD_SIZE = 8,
  parameter  int NUM_CH    = 5,
  localparam int SEL_WIDTH = $clog2(NUM_CH)
) (
  input logic          clk,
  input logic          rst,
  mux_nch_reg_if.slave bus
);

  localparam logic [SEL_WIDTH:0]     NUM_CH_X  = (SEL_WIDTH + 1)'(NUM_CH);
  localparam logic [SEL_WIDTH-1:0]   LAST_CH   = SEL_WIDTH'(NUM_CH - 1);
  localparam logic [WORD_SIZE-1:0]   DATA_ZERO = WORD_ZERO[WORD_SIZE-1:0];

  logic [WORD_SIZE-1:0] out_data_q,  out_data_d;
  logic [SEL_WIDTH-1:0] out_ch_q,    out_ch_d;
  logic                 out_valid_q, out_valid_d;
  logic                 sel_err_q,   sel_err_d;
  logic [SEL_WIDTH-1:0] rr_last_q,   rr_last_d;

  logic [WORD_SIZE-1:0] ch_word [NUM_CH];
  logic [NUM_CH-1:0]    in_ready_vec;
  logic [SEL_WIDTH-1:0] rr_gnt;
  logic                 rr_gnt_valid;
  logic [SEL_WIDTH-1:0] gnt_idx;
  logic                 gnt_valid;
  logic [WORD_SIZE-1:0] gnt_word;
  logic                 sel_in_range;
  logic                 free;
  logic                 xfer;

  // The slot can take a new word when empty or when it is being read out in
  // this same cycle, which allows back-to-back transfers.
  assign free         = !out_valid_q || bus.out_ready;
  assign sel_in_range = ({1'b0, bus.sel} < NUM_CH_X);

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr_arbiter (
    .req_i       (bus.in_valid),
    .last_i      (rr_last_q),
    .gnt_o       (rr_gnt),
    .gnt_valid_o (rr_gnt_valid)
  );

  // Grant source follows the mode input directly, so a mode change applies
  // in the same cycle. Directed grants ignore in_valid entirely, which keeps
  // in_ready free of any combinational dependence on in_valid in that mode.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    if (bus.mode == MODE_RR) begin
      gnt_idx   = rr_gnt;
      gnt_valid = rr_gnt_valid;
    end else begin
      gnt_idx   = bus.sel;
      gnt_valid = sel_in_range;
    end
  end

  // Unpack channel words and build the one-hot ready vector.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_word[gi]      = bus.data_in[gi*WORD_SIZE +: WORD_SIZE];
    assign in_ready_vec[gi] = free && gnt_valid && (gnt_idx == SEL_WIDTH'(gi));
  end

  // Granted word selected by equality compare so an unused select code never
  // indexes past the last channel.
  always_comb begin
    gnt_word = DATA_ZERO;
    for (int k = 0; k < NUM_CH; k++) begin
      if (gnt_idx == SEL_WIDTH'(k)) begin
        gnt_word = ch_word[k];
      end
    end
  end

  assign xfer = |(in_ready_vec & bus.in_valid);

  // Next-state for the output slot, select-error flag and round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_last_d   = rr_last_q;
    sel_err_d   = (bus.mode == MODE_DIRECTED) && !sel_in_range;
    if (xfer) begin
      out_data_d  = gnt_word;
      out_ch_d    = gnt_idx;
      out_valid_d = 1'b1;
      // Directed transfers leave the pointer alone so round-robin resumes
      // where it left off.
      if (bus.mode == MODE_RR) begin
        rr_last_d = gnt_idx;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset overrides any transfer in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= DATA_ZERO;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      rr_last_q   <= LAST_CH;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
      rr_last_q   <= rr_last_d;
    end
  end

  assign bus.in_ready  = in_ready_vec;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_nch_reg.sv
// Bench for mux_nch_reg: two instances (8-bit x 5 channels, 16-bit x 3
// channels) driven by directed scenarios followed by random traffic, with a
// per-cycle reference model and literal expectations at key points.
module tb_mux_nch_reg;
  import risc_spm_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input int cfg,
                       input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cfg%0d actual=%0h required=%0h", name, cfg, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int WS       = (gi == 0) ? 8 : 16;
    localparam int NC       = (gi == 0) ? 5 : 3;
    localparam int SW       = $clog2(NC);
    localparam int SEL_SPAN = 1 << SW;

    mux_nch_reg_if #(.WORD_SIZE(WS), .NUM_CH(NC)) bus ();
    mux_nch_reg #(.WORD_SIZE(WS), .NUM_CH(NC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    bit            done    = 1'b0;
    bit            m_known = 1'b0;
    bit            m_valid = 1'b0;
    bit            m_err   = 1'b0;
    logic [WS-1:0] m_data  = '0;
    int            m_ch    = 0;
    int            m_rr    = 0;

    // Directed data: AA..EE for the byte instance, alternating A5A5/5A5A
    // for the 16-bit instance so every bit toggles both ways.
    function automatic logic [WS-1:0] pattern(input int ch);
      if (gi == 0) return WS'(32'hAA + 32'h11 * ch);
      return ((ch % 2) == 0) ? WS'(32'hA5A5) : WS'(32'h5A5A);
    endfunction

    // Scan order after the last grant, wrapping around.
    function automatic int rr_pick(input int last, input logic [NC-1:0] v);
      for (int k = 1; k <= NC; k++) begin
        if (v[(last + k) % NC]) return (last + k) % NC;
      end
      return -1;
    endfunction

    function automatic int grant_of(input logic md, input int s,
                                    input logic [NC-1:0] v, input int last);
      if (md == MODE_DIRECTED) return (s < NC) ? s : -1;
      return rr_pick(last, v);
    endfunction

    // Reference model: compare at the falling edge, advance at the rising edge.
    initial begin : p_model
      int            g;
      bit            free_m;
      bit            xfer;
      logic [NC-1:0] exp_rdy;
      bit            n_known, n_valid, n_err;
      logic [WS-1:0] n_data;
      int            n_ch, n_rr;
      forever begin
        @(negedge clk);
        g       = grant_of(bus.mode, int'(bus.sel), bus.in_valid, m_rr);
        free_m  = !m_valid || bus.out_ready;
        exp_rdy = '0;
        if (g >= 0 && free_m) exp_rdy[g] = 1'b1;
        xfer    = (g >= 0) && free_m && (bus.in_valid[g] == 1'b1);
        if (m_known) begin
          check("out_valid", gi, bus.out_valid, m_valid);
          check("out_data", gi, bus.out_data, m_data);
          check("out_ch", gi, bus.out_ch, m_ch);
          check("sel_err", gi, bus.sel_err, m_err);
          check("in_ready", gi, bus.in_ready, exp_rdy);
        end
        n_known = m_known;
        n_valid = m_valid;
        n_err   = m_err;
        n_data  = m_data;
        n_ch    = m_ch;
        n_rr    = m_rr;
        if (rst) begin
          n_known = 1'b1;
          n_valid = 1'b0;
          n_err   = 1'b0;
          n_data  = '0;
          n_ch    = 0;
          n_rr    = NC - 1;
        end else begin
          n_err = (bus.mode == MODE_DIRECTED) && (int'(bus.sel) >= NC);
          if (xfer) begin
            n_valid = 1'b1;
            n_data  = bus.data_in[g*WS +: WS];
            n_ch    = g;
            if (bus.mode == MODE_RR) n_rr = g;
            $display("cfg%0d xfer mode=%0d ch=%0d data=%0h", gi, bus.mode, g, n_data);
          end else if (m_valid && bus.out_ready) begin
            n_valid = 1'b0;
          end
        end
        @(posedge clk);
        m_known = n_known;
        m_valid = n_valid;
        m_err   = n_err;
        m_data  = n_data;
        m_ch    = n_ch;
        m_rr    = n_rr;
      end
    end

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    // Literal expectation applied to both the DUT and the model.
    task automatic lit(input string name, input logic [63:0] dut_v,
                       input logic [63:0] mdl_v, input logic [63:0] exp);
      check(name, gi, dut_v, exp);
      check({name, "_model"}, gi, mdl_v, exp);
    endtask

    initial begin : p_stim
      logic [NC*WS-1:0] pat_bus;
      int               gap_exp [5];
      for (int c = 0; c < NC; c++) pat_bus[c*WS +: WS] = pattern(c);
      bus.data_in   = pat_bus;
      bus.in_valid  = '1;
      bus.out_ready = 1'b1;
      bus.mode      = MODE_DIRECTED;
      bus.sel       = '0;

      // Reset held with a transfer pending: reset must win.
      repeat (2) begin
        tick();
        check("rst_out_valid", gi, bus.out_valid, 1'b0);
        check("rst_out_data", gi, bus.out_data, 64'h0);
      end
      bus.in_valid = '0;
      tick();
      lit("post_rst_valid", bus.out_valid, m_valid, 1'b0);
      lit("post_rst_sel_err", bus.sel_err, m_err, 1'b0);

      // Directed sweep over every select code, including out-of-range ones.
      bus.in_valid = '1;
      for (int s = 0; s < SEL_SPAN; s++) begin
        bus.sel = SW'(s);
        tick();
        lit("dir_valid", bus.out_valid, m_valid, (s < NC));
        lit("dir_sel_err", bus.sel_err, m_err, (s >= NC));
        if (s < NC) begin
          lit("dir_data", bus.out_data, m_data, pattern(s));
          lit("dir_ch", bus.out_ch, m_ch, s);
        end
      end

      // Backpressure on channel 2.
      bus.sel = SW'(2);
      tick();
      lit("bp_first", bus.out_data, m_data, pattern(2));
      bus.out_ready = 1'b0;
      repeat (3) begin
        tick();
        lit("bp_hold_valid", bus.out_valid, m_valid, 1'b1);
        lit("bp_hold_data", bus.out_data, m_data, pattern(2));
        check("bp_in_ready", gi, bus.in_ready, 64'h0);
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp_release_ready", gi, bus.in_ready, 64'h4);
      tick();
      lit("bp_refill_valid", bus.out_valid, m_valid, 1'b1);
      lit("bp_refill_data", bus.out_data, m_data, pattern(2));

      // Round-robin fairness from the post-reset pointer.
      bus.mode = MODE_RR;
      for (int k = 0; k < 2 * NC; k++) begin
        tick();
        lit("rr_ch", bus.out_ch, m_ch, k % NC);
        lit("rr_data", bus.out_data, m_data, pattern(k % NC));
      end

      // Round-robin with gaps: seed the pointer at 1, then channels 1 and top.
      bus.in_valid = NC'(2);
      tick();
      lit("gap_seed", bus.out_ch, m_ch, 1);
      gap_exp = '{NC - 1, 1, NC - 1, 1, 1};
      for (int k = 0; k < 5; k++) begin
        bus.in_valid = (k < 3) ? (NC'(2) | (NC'(1) << (NC - 1))) : NC'(2);
        tick();
        lit("gap_ch", bus.out_ch, m_ch, gap_exp[k]);
        lit("gap_valid", bus.out_valid, m_valid, 1'b1);
      end

      // Random traffic, mixed modes, select codes and backpressure.
      for (int n = 0; n < 300; n++) begin
        bus.data_in   = (NC*WS)'({$urandom(), $urandom()});
        bus.in_valid  = NC'($urandom());
        bus.mode      = 1'($urandom_range(0, 1));
        bus.sel       = SW'($urandom_range(0, SEL_SPAN - 1));
        bus.out_ready = ($urandom_range(0, 9) < 7);
        tick();
      end
      done = 1'b1;
    end
  end

  initial begin : p_main
    bit finished;
    rst      = 1'b1;
    finished = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int cyc = 0; cyc < 5000 && !finished; cyc++) begin
      @(posedge clk);
      finished = g_cfg[0].done && g_cfg[1].done;
    end
    checks++;
    if (!finished) begin
      failures++;
      $display("FAIL timeout actual=%0d required=1", finished);
    end
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
